// File: rtl/pe_loop_sequencer_pkg.sv
// Shared PE control package: sequencer state encoding and default loop-index widths.
package pe_loop_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_WORK = 2'd2,
    ST_DONE = 2'd3
  } seq_state_t;

  localparam int SW_DEF = 3;
  localparam int CW_DEF = 5;
  localparam int WW_DEF = 6;

endpackage

// File: rtl/pe_loop_sequencer_counter.sv
// Nested S/C/W wrap-and-carry index counter: S innermost, W outermost.
module pe_loop_counter
  import pe_loop_sequencer_pkg::*;
#(
  parameter int SW = SW_DEF,
  parameter int CW = CW_DEF,
  parameter int WW = WW_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_adv,
  input  logic [SW-1:0] i_cnt_s,
  input  logic [CW-1:0] i_cnt_c,
  input  logic [WW-1:0] i_cnt_w,
  output logic [SW-1:0] o_s,
  output logic [CW-1:0] o_c,
  output logic [WW-1:0] o_w,
  output logic          o_s_last,
  output logic          o_c_last,
  output logic          o_w_last
);

  assign o_s_last = (o_s == i_cnt_s - SW'(1));
  assign o_c_last = (o_c == i_cnt_c - CW'(1));
  assign o_w_last = (o_w == i_cnt_w - WW'(1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_s <= '0;
      o_c <= '0;
      o_w <= '0;
    end else if (i_clr) begin
      o_s <= '0;
      o_c <= '0;
      o_w <= '0;
    end else if (i_adv) begin
      // each field only moves when every inner field wraps
      if (o_s_last) begin
        o_s <= '0;
        if (o_c_last) begin
          o_c <= '0;
          if (o_w_last) o_w <= '0;
          else          o_w <= o_w + WW'(1);
        end else begin
          o_c <= o_c + CW'(1);
        end
      end else begin
        o_s <= o_s + SW'(1);
      end
    end
  end

endmodule

// File: rtl/pe_loop_sequencer.sv
// PE loop sequencer: walks S/C/W loop indices for one job, one beat per valid/ready handshake.
module pe_loop_sequencer
  import pe_loop_sequencer_pkg::*;
#(
  parameter int SW = SW_DEF,
  parameter int CW = CW_DEF,
  parameter int WW = WW_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic [SW-1:0] i_cfg_s,
  input  logic [CW-1:0] i_cfg_c,
  input  logic [WW-1:0] i_cfg_w,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [SW-1:0] o_s_idx,
  output logic [CW-1:0] o_c_idx,
  output logic [WW-1:0] o_w_idx,
  output logic          o_first,
  output logic          o_last,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_error
);

  seq_state_t    state;
  logic [SW-1:0] cnt_s;
  logic [CW-1:0] cnt_c;
  logic [WW-1:0] cnt_w;
  logic          s_last;
  logic          c_last;
  logic          w_last;
  logic          cfg_ok;
  logic          start_ok;
  logic          beat_acc;

  assign cfg_ok   = (i_cfg_s != '0) && (i_cfg_c != '0) && (i_cfg_w != '0);
  assign start_ok = (state == ST_IDLE) && i_start && cfg_ok;
  // abort outranks acceptance, so an aborted beat never advances the indices
  assign beat_acc = (state == ST_WORK) && i_ready && !i_abort;

  pe_loop_counter #(
    .SW(SW),
    .CW(CW),
    .WW(WW)
  ) u_counter (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    (start_ok),
    .i_adv    (beat_acc),
    .i_cnt_s  (cnt_s),
    .i_cnt_c  (cnt_c),
    .i_cnt_w  (cnt_w),
    .o_s      (o_s_idx),
    .o_c      (o_c_idx),
    .o_w      (o_w_idx),
    .o_s_last (s_last),
    .o_c_last (c_last),
    .o_w_last (w_last)
  );

  assign o_first = o_valid && (o_s_idx == '0) && (o_c_idx == '0);
  assign o_last  = o_valid && s_last && c_last;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      cnt_s   <= '0;
      cnt_c   <= '0;
      cnt_w   <= '0;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_error <= 1'b0;
    end else begin
      // a start is an error when busy or when any loop count is zero
      o_error <= i_start && ((state != ST_IDLE) || !cfg_ok);
      o_done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            state  <= ST_INIT;
            cnt_s  <= i_cfg_s;
            cnt_c  <= i_cfg_c;
            cnt_w  <= i_cfg_w;
            o_busy <= 1'b1;
          end
        end
        ST_INIT: begin
          if (i_abort) begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end else begin
            state   <= ST_WORK;
            o_valid <= 1'b1;
          end
        end
        ST_WORK: begin
          if (i_abort) begin
            state   <= ST_IDLE;
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
          end else if (beat_acc && s_last && c_last && w_last) begin
            state   <= ST_DONE;
            o_valid <= 1'b0;
            o_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
        end
        default: begin
          state   <= ST_IDLE;
          o_valid <= 1'b0;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_loop_sequencer.sv
// Directed bench for pe_loop_sequencer: full jobs, stalls, abort, errors and async reset.
module tb_pe_loop_sequencer;
  localparam int SW = 3;
  localparam int CW = 5;
  localparam int WW = 6;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_start;
  logic          i_abort;
  logic [SW-1:0] i_cfg_s;
  logic [CW-1:0] i_cfg_c;
  logic [WW-1:0] i_cfg_w;
  logic          o_valid;
  logic          i_ready;
  logic [SW-1:0] o_s_idx;
  logic [CW-1:0] o_c_idx;
  logic [WW-1:0] o_w_idx;
  logic          o_first;
  logic          o_last;
  logic          o_busy;
  logic          o_done;
  logic          o_error;

  int tests = 0;
  int fails = 0;

  always #5 i_clk = ~i_clk;

  pe_loop_sequencer #(
    .SW(SW),
    .CW(CW),
    .WW(WW)
  ) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (i_start),
    .i_abort (i_abort),
    .i_cfg_s (i_cfg_s),
    .i_cfg_c (i_cfg_c),
    .i_cfg_w (i_cfg_w),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_s_idx (o_s_idx),
    .o_c_idx (o_c_idx),
    .o_w_idx (o_w_idx),
    .o_first (o_first),
    .o_last  (o_last),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_error (o_error)
  );

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: ready always high; mode 1: ready pattern 1,0,0,1 repeating.
  // start_beat / abort_after: beat number (0-based) at which to inject, -1 = never.
  task automatic run_job(input int ns, input int nc, input int nw, input int mode,
                         input int start_beat, input int abort_after, input bit abort_on_start);
    int b;
    int cyc;
    bit acc;
    bit rdy;
    bit aborted;
    bit injected;
    bit err_pend;
    b = 0; cyc = 0; aborted = 0; injected = 0; err_pend = 0;
    i_cfg_s = SW'(ns); i_cfg_c = CW'(nc); i_cfg_w = WW'(nw);
    i_start = 1'b1;
    i_abort = abort_on_start;
    tick;
    i_start = 1'b0; i_abort = 1'b0;
    i_cfg_s = '0; i_cfg_c = '0; i_cfg_w = '0;
    chk("init_valid", o_valid, 0);
    chk("init_busy", o_busy, 1);
    chk("init_error", o_error, 0);
    i_ready = 1'b1;
    tick;
    for (int w = 0; w < nw; w++) begin
      for (int c = 0; c < nc; c++) begin
        for (int s = 0; s < ns; s++) begin
          if (!aborted) begin
            acc = 0;
            while (!acc) begin
              chk("beat_valid", o_valid, 1);
              chk("beat_s", o_s_idx, s);
              chk("beat_c", o_c_idx, c);
              chk("beat_w", o_w_idx, w);
              chk("beat_first", o_first, (s == 0 && c == 0));
              chk("beat_last", o_last, (s == ns - 1 && c == nc - 1));
              chk("beat_busy", o_busy, 1);
              chk("beat_done", o_done, 0);
              chk("beat_error", o_error, err_pend);
              err_pend = 0;
              rdy = (mode == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
              i_ready = rdy;
              if (b == start_beat && !injected) begin
                i_start = 1'b1;
                i_cfg_s = 1; i_cfg_c = 1; i_cfg_w = 1;
                injected = 1;
                err_pend = 1;
              end
              if (b == abort_after) i_abort = 1'b1;
              tick;
              i_start = 1'b0;
              i_cfg_s = '0; i_cfg_c = '0; i_cfg_w = '0;
              cyc++;
              if (i_abort) begin
                i_abort = 1'b0;
                aborted = 1;
                acc = 1;
              end else begin
                acc = rdy;
              end
            end
            b++;
          end
        end
      end
    end
    i_ready = 1'b1;
    if (aborted) begin
      chk("abort_valid", o_valid, 0);
      chk("abort_busy", o_busy, 0);
      chk("abort_done", o_done, 0);
      chk("abort_error", o_error, err_pend);
      tick;
      chk("abort_done2", o_done, 0);
      chk("abort_valid2", o_valid, 0);
    end else begin
      chk("end_done", o_done, 1);
      chk("end_valid", o_valid, 0);
      chk("end_busy", o_busy, 1);
      chk("end_error", o_error, err_pend);
      tick;
      chk("idle_done", o_done, 0);
      chk("idle_busy", o_busy, 0);
      chk("idle_valid", o_valid, 0);
      chk("idle_error", o_error, 0);
    end
  endtask

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_ready = 1'b0;
    i_cfg_s = '0; i_cfg_c = '0; i_cfg_w = '0;
    tick;
    tick;
    chk("rst_valid", o_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_error", o_error, 0);
    chk("rst_first", o_first, 0);
    chk("rst_last", o_last, 0);
    chk("rst_idx", {o_s_idx, o_c_idx, o_w_idx}, 0);
    i_rst = 1'b0;
    tick;
    chk("post_rst_busy", o_busy, 0);

    // 3x2x2 with ready tied high
    run_job(3, 2, 2, 0, -1, -1, 0);
    // single-beat job
    run_job(1, 1, 1, 0, -1, -1, 0);
    // 3x2x2 with ready stalls
    run_job(3, 2, 2, 1, -1, -1, 0);
    // start during WORK is rejected, job continues unchanged
    run_job(3, 2, 2, 0, 4, -1, 0);
    // abort after five accepted beats
    run_job(3, 2, 2, 0, -1, 5, 0);
    // start and abort together in IDLE behaves as start
    run_job(2, 1, 1, 0, -1, -1, 1);

    // zero channel count: rejected with error, no beats
    i_cfg_s = 3; i_cfg_c = 0; i_cfg_w = 2;
    i_start = 1'b1;
    tick;
    i_start = 1'b0;
    i_cfg_s = '0; i_cfg_w = '0;
    chk("zero_error", o_error, 1);
    chk("zero_busy", o_busy, 0);
    chk("zero_valid", o_valid, 0);
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("zero_valid_hold", o_valid, 0);
      chk("zero_busy_hold", o_busy, 0);
      chk("zero_error_hold", o_error, 0);
    end

    // asynchronous reset in the middle of a job
    i_cfg_s = 3; i_cfg_c = 2; i_cfg_w = 2;
    i_start = 1'b1;
    i_ready = 1'b1;
    tick;
    i_start = 1'b0;
    tick;
    tick;
    tick;
    tick;
    chk("pre_rst_valid", o_valid, 1);
    chk("pre_rst_c", o_c_idx, 1);
    #2;
    i_rst = 1'b1;
    #1;
    chk("arst_valid", o_valid, 0);
    chk("arst_busy", o_busy, 0);
    chk("arst_first", o_first, 0);
    chk("arst_last", o_last, 0);
    chk("arst_done", o_done, 0);
    chk("arst_idx", {o_s_idx, o_c_idx, o_w_idx}, 0);
    tick;
    tick;
    i_rst = 1'b0;
    i_cfg_s = '0; i_cfg_c = '0; i_cfg_w = '0;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("post_arst_done", o_done, 0);
      chk("post_arst_valid", o_valid, 0);
    end
    run_job(3, 2, 2, 1, -1, -1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
